sync_fifo_flags: RTL and testbench



---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_mem_dp.sv | 27 ++
 rtl/sync_fifo_flags.sv | 118 +++++++++++
 tb/tb_sync_fifo_flags.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and the read-mode enumeration for the flagged FIFO.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD,
        FIFO_FWFT
    } fifo_mode_e;

    // Address width for a DEPTH-entry array.
    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Count/pointer width: one extra bit so a full FIFO (count == DEPTH) is representable.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset of contents.
module fifo_mem_dp
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [addr_w(DEPTH)-1:0]    waddr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic [addr_w(DEPTH)-1:0]    raddr,
    output logic [DATA_WIDTH-1:0]       rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Store a word on an accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, error pulses and
// selectable standard or first-word-fall-through read behaviour.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = 2,
    parameter int unsigned FWFT       = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      w_en,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      r_en,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      write_error,
    output logic                      read_error
);

    localparam int unsigned AW = addr_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_flags: DEPTH must be a power of two and >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH > DEPTH - 1) begin : g_bad_thresh
        $error("sync_fifo_flags: threshold out of range");
    end

    logic [CW-1:0]         wr_ptr_q, rd_ptr_q, count_q, count_d;
    logic                  full_q, empty_q, af_q, ae_q;
    logic                  werr_q, rerr_q;
    logic [DATA_WIDTH-1:0] dout_q, rd_data;
    logic                  wr_acc, rd_acc;

    // Pointer MSBs only carry wrap parity; occupancy comes from the count.
    logic unused_ptr_msb;
    assign unused_ptr_msb = ^{wr_ptr_q[CW-1], rd_ptr_q[CW-1]};

    // Accept decisions use the flags as registered before the edge.
    always_comb begin
        wr_acc  = w_en & ~full_q;
        rd_acc  = r_en & ~empty_q;
        count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
    end

    fifo_mem_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc & ~rst),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_data)
    );

    // Pointers, count, flags and error pulses; flags are registered from the next count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            werr_q   <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
            af_q    <= (count_d >= CW'(AF_THRESH));
            ae_q    <= (count_d <= CW'(AE_THRESH));
            werr_q  <= w_en & full_q;
            rerr_q  <= r_en & empty_q;
        end
    end

    // Registered read port used in standard mode; holds between accepted reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= rd_data;
        end
    end

    // Output select: FWFT shows the head word directly, zero while empty.
    always_comb begin
        if (MODE == FIFO_FWFT) begin
            data_out = empty_q ? '0 : rd_data;
        end else begin
            data_out = dout_q;
        end
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign write_error  = werr_q;
    assign read_error   = rerr_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a standard and an FWFT instance share stimulus and are checked
// every cycle against a queue-based model, with literal checks on directed scenarios.
module tb_sync_fifo_flags;

    localparam int unsigned DW = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF = DEPTH - 2;
    localparam int unsigned AE = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          w_en = 1'b0;
    logic          r_en = 1'b0;
    logic [DW-1:0] data_in = '0;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_full, s_empty, s_af, s_ae, s_werr, s_rerr;
    logic          f_full, f_empty, f_af, f_ae, f_werr, f_rerr;
    logic [4:0]    s_count, f_count;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    bit            m_werr = 1'b0;
    bit            m_rerr = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE),
                      .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_count), .write_error(s_werr), .read_error(s_rerr)
    );

    sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE),
                      .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .write_error(f_werr), .read_error(f_rerr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of stored words, updated at each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                m_dout = '0;
                m_werr = 1'b0;
                m_rerr = 1'b0;
            end else begin
                automatic int n = q.size();
                m_werr = w_en && (n == DEPTH);
                m_rerr = r_en && (n == 0);
                if (r_en && n > 0) m_dout = q.pop_front();
                if (w_en && n < DEPTH) q.push_back(data_in);
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                automatic int n = q.size();
                check("std.count", 32'(s_count), 32'(n));
                check("fwft.count", 32'(f_count), 32'(n));
                check("std.flags", {s_full, s_empty, s_af, s_ae},
                      {n == DEPTH, n == 0, n >= AF, n <= AE});
                check("fwft.flags", {f_full, f_empty, f_af, f_ae},
                      {n == DEPTH, n == 0, n >= AF, n <= AE});
                check("std.errors", {s_werr, s_rerr}, {m_werr, m_rerr});
                check("fwft.errors", {f_werr, f_rerr}, {m_werr, m_rerr});
                check("std.data_out", 32'(s_dout), 32'(m_dout));
                if (n > 0) check("fwft.data_out", 32'(f_dout), 32'(q[0]));
                if (s_werr && s_rerr) check("both_errors", 32'(1), 32'(0));
            end
        end
    end

    // Apply one cycle of inputs, returning at the following falling edge.
    task automatic cyc(input bit rs, input bit w, input logic [DW-1:0] d, input bit r);
        rst = rs;
        w_en = w;
        data_in = d;
        r_en = r;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        check("reset.flags", {s_empty, s_ae, s_full, s_af}, 4'b1100);
        check("reset.count", 32'(s_count), 0);
        check("reset.data_out", 32'(s_dout), 0);
        check("reset.errors", {s_werr, s_rerr}, 2'b00);

        // Read on empty
        cyc(0, 0, 0, 1);
        check("rd_empty.read_error", 32'(s_rerr), 1);
        check("rd_empty.count", 32'(s_count), 0);
        check("rd_empty.data_out", 32'(s_dout), 0);
        cyc(0, 0, 0, 0);
        check("rd_empty.pulse_end", 32'(s_rerr), 0);

        // Fill to full
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 1, DW'(i), 0);
            if (i == 13) check("fill.af_at13", 32'(s_af), 0);
            if (i == 14) check("fill.af_at14", 32'(s_af), 1);
        end
        check("fill.count", 32'(s_count), 16);
        check("fill.full", 32'(s_full), 1);
        cyc(0, 1, 8'hFF, 0);
        check("overflow.write_error", 32'(s_werr), 1);
        check("overflow.count", 32'(s_count), 16);
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 0, 0, 1);
            if (i == 1) check("overflow.pulse_end", 32'(s_werr), 0);
            check("drain.data_out", 32'(s_dout), 32'(i));
        end
        check("drain.empty", 32'(s_empty), 1);

        // Steady state at 8 entries across pointer wrap
        for (int i = 0; i < 8; i++) cyc(0, 1, DW'(8'h20 + i), 0);
        for (int i = 0; i < 20; i++) cyc(0, 1, DW'(8'h40 + i), 1);
        check("stream.count", 32'(s_count), 8);
        check("stream.last_out", 32'(s_dout), 32'(8'h4B));

        // FWFT fall-through
        cyc(1, 0, 0, 0);
        cyc(0, 1, 8'hA5, 0);
        check("fwft.empty_after_wr", 32'(f_empty), 0);
        check("fwft.head", 32'(f_dout), 32'(8'hA5));
        cyc(0, 0, 0, 1);
        check("fwft.empty_after_pop", 32'(f_empty), 1);

        // Reset overrides a write
        for (int i = 0; i < 10; i++) cyc(0, 1, DW'(i), 0);
        check("prerst.count", 32'(s_count), 10);
        cyc(1, 1, 8'h77, 0);
        check("rst_wr.count", 32'(s_count), 0);
        check("rst_wr.empty", 32'(s_empty), 1);
        cyc(0, 0, 0, 0);
        check("rst_wr.no_write", 32'(s_count), 0);

        // Randomised traffic with varying bias
        for (int i = 0; i < 1500; i++) begin
            automatic int phase = (i / 150) % 3;
            automatic bit w = (phase == 0) ? ($urandom_range(0, 3) != 0) :
                              (phase == 1) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
            automatic bit r = (phase == 1) ? ($urandom_range(0, 3) != 0) :
                              (phase == 0) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
            cyc($urandom_range(0, 199) == 0, w, DW'($urandom), r);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
